id_ex_stage: RTL

ID/EX pipeline stage of the pipelined RV32I core. It registers the decoded control bundle produced by the main decoder together with the ID-stage operands. It detects load-use hazards and inserts one bubble per hazard, and it squashes the stage on a taken branch or jump resolved in EX. It sits between the ID-stage decoder/register file and the EX-stage ALU/branch logic.

---
 rtl/riscv_pkg.sv | 45 ++++
 rtl/load_use_detect.sv | 29 ++
 rtl/id_ex_stage.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: opcodes, writeback/jump encodings, the decoded
// control bundle and register-use helpers.
package riscv_pkg;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [1:0] TOREG_ALU = 2'd0;
  localparam logic [1:0] TOREG_MEM = 2'd1;
  localparam logic [1:0] TOREG_PC4 = 2'd2;

  localparam logic [1:0] JUMP_NONE = 2'b00;
  localparam logic [1:0] JUMP_JAL  = 2'b01;
  localparam logic [1:0] JUMP_JALR = 2'b11;

  typedef struct packed {
    logic       branch;
    logic       memread;
    logic       add;
    logic       memwrite;
    logic       regwrite;
    logic       immediate;
    logic [1:0] jump;
    logic [1:0] toreg;
  } ctrl_t;

  // All-zero bundle: no register write, no memory access, no redirect.
  localparam ctrl_t CTRL_BUBBLE = '{branch: 1'b0, memread: 1'b0, add: 1'b0,
                                    memwrite: 1'b0, regwrite: 1'b0, immediate: 1'b0,
                                    jump: JUMP_NONE, toreg: TOREG_ALU};

  function automatic logic uses_rs1(input logic [6:0] opc);
    return (opc != OPC_JAL);
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opc);
    return (opc == OPC_R) || (opc == OPC_STORE) || (opc == OPC_BRANCH);
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector: the ID instruction reads a register
// that the load currently in EX has not yet fetched from memory.
module load_use_detect
  import riscv_pkg::*;
(
  input  logic [6:0] i_id_opcode,
  input  logic [4:0] i_id_rs1,
  input  logic [4:0] i_id_rs2,
  input  logic       i_ex_valid,
  input  logic       i_ex_memread,
  input  logic [4:0] i_ex_rd,
  output logic       o_load_use
);

  logic w_use_rs1;
  logic w_use_rs2;
  logic w_ex_is_load;
  logic w_rs1_hit;
  logic w_rs2_hit;

  assign w_use_rs1    = uses_rs1(i_id_opcode);
  assign w_use_rs2    = uses_rs2(i_id_opcode);
  // A load into x0 produces nothing to wait for.
  assign w_ex_is_load = i_ex_valid & i_ex_memread & (i_ex_rd != 5'd0);
  assign w_rs1_hit    = w_use_rs1 & (i_id_rs1 == i_ex_rd);
  assign w_rs2_hit    = w_use_rs2 & (i_id_rs2 == i_ex_rd);
  assign o_load_use   = w_ex_is_load & (w_rs1_hit | w_rs2_hit);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures the decoded bundle and operands, inserts a
// single bubble per load-use hazard and squashes on an EX-resolved redirect.
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       id_opcode,
  input  logic             id_branch,
  input  logic             id_memread,
  input  logic             id_add,
  input  logic             id_memwrite,
  input  logic             id_regwrite,
  input  logic             id_immediate,
  input  logic [1:0]       id_toreg,
  input  logic [1:0]       id_jump,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic [2:0]       id_funct3,
  input  logic             id_funct7b5,
  input  logic             ex_flush,
  input  logic             hold,
  output logic             stall,
  output logic             flush_ifid,
  output logic             ex_valid,
  output logic             ex_branch,
  output logic             ex_memread,
  output logic             ex_add,
  output logic             ex_memwrite,
  output logic             ex_regwrite,
  output logic             ex_immediate,
  output logic [1:0]       ex_toreg,
  output logic [1:0]       ex_jump,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_rs1_data,
  output logic [XLEN-1:0]  ex_rs2_data,
  output logic [XLEN-1:0]  ex_imm,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic [2:0]       ex_funct3,
  output logic             ex_funct7b5,
  output logic [CNT_W-1:0] bubble_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             r_valid;
  ctrl_t            r_ctrl;
  logic [XLEN-1:0]  r_pc;
  logic [XLEN-1:0]  r_rs1_data;
  logic [XLEN-1:0]  r_rs2_data;
  logic [XLEN-1:0]  r_imm;
  logic [4:0]       r_rs1;
  logic [4:0]       r_rs2;
  logic [4:0]       r_rd;
  logic [2:0]       r_funct3;
  logic             r_funct7b5;
  logic [CNT_W-1:0] r_bubble_count;
  logic [CNT_W-1:0] r_flush_count;

  ctrl_t            w_id_ctrl;
  logic             w_load_use;

  assign w_id_ctrl = '{branch: id_branch, memread: id_memread, add: id_add,
                       memwrite: id_memwrite, regwrite: id_regwrite,
                       immediate: id_immediate, jump: id_jump, toreg: id_toreg};

  load_use_detect u_load_use_detect (
    .i_id_opcode  (id_opcode),
    .i_id_rs1     (id_rs1),
    .i_id_rs2     (id_rs2),
    .i_ex_valid   (r_valid),
    .i_ex_memread (r_ctrl.memread),
    .i_ex_rd      (r_rd),
    .o_load_use   (w_load_use)
  );

  // A redirect beats the hazard: IF/ID is being replaced, not frozen.
  assign stall      = hold | (w_load_use & ~ex_flush);
  assign flush_ifid = ex_flush & ~hold;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid        <= 1'b0;
      r_ctrl         <= CTRL_BUBBLE;
      r_pc           <= '0;
      r_rs1_data     <= '0;
      r_rs2_data     <= '0;
      r_imm          <= '0;
      r_rs1          <= '0;
      r_rs2          <= '0;
      r_rd           <= '0;
      r_funct3       <= '0;
      r_funct7b5     <= 1'b0;
      r_bubble_count <= '0;
      r_flush_count  <= '0;
    end else if (!hold) begin
      // Data fields always follow ID; only control/valid distinguish a bubble.
      r_pc       <= id_pc;
      r_rs1_data <= id_rs1_data;
      r_rs2_data <= id_rs2_data;
      r_imm      <= id_imm;
      r_rs1      <= id_rs1;
      r_rs2      <= id_rs2;
      r_rd       <= id_rd;
      r_funct3   <= id_funct3;
      r_funct7b5 <= id_funct7b5;
      if (ex_flush) begin
        r_valid       <= 1'b0;
        r_ctrl        <= CTRL_BUBBLE;
        r_flush_count <= r_flush_count + CNT_ONE;
      end else if (w_load_use) begin
        r_valid        <= 1'b0;
        r_ctrl         <= CTRL_BUBBLE;
        r_bubble_count <= r_bubble_count + CNT_ONE;
      end else begin
        r_valid <= 1'b1;
        r_ctrl  <= w_id_ctrl;
      end
    end
  end

  assign ex_valid     = r_valid;
  assign ex_branch    = r_ctrl.branch;
  assign ex_memread   = r_ctrl.memread;
  assign ex_add       = r_ctrl.add;
  assign ex_memwrite  = r_ctrl.memwrite;
  assign ex_regwrite  = r_ctrl.regwrite;
  assign ex_immediate = r_ctrl.immediate;
  assign ex_toreg     = r_ctrl.toreg;
  assign ex_jump      = r_ctrl.jump;
  assign ex_pc        = r_pc;
  assign ex_rs1_data  = r_rs1_data;
  assign ex_rs2_data  = r_rs2_data;
  assign ex_imm       = r_imm;
  assign ex_rs1       = r_rs1;
  assign ex_rs2       = r_rs2;
  assign ex_rd        = r_rd;
  assign ex_funct3    = r_funct3;
  assign ex_funct7b5  = r_funct7b5;
  assign bubble_count = r_bubble_count;
  assign flush_count  = r_flush_count;

endmodule
